// File: rtl/bcd_add_serial.sv
// bcd_add_serial: digit-serial packed-BCD adder with start/busy/done handshake.
// One BCD digit is added per clock, least-significant digit first. The decimal
// carry ripples through a register between digits.
// Optional build macro BCD_DIGIT_CHECK_EN: when defined, err flags any operand
// digit above 9 on an accepted start; when undefined, err is tied to 0.
module bcd_add_serial #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic [4*DIGITS-1:0] s,
    output logic                cout,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_s;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic [IDX_W+1:0] w_bit_base;
    logic [3:0]       w_a_dig;
    logic [3:0]       w_b_dig;
    logic [4:0]       w_t;
    logic             w_carry_next;
    logic [3:0]       w_digit;

    // A start is only honoured when no addition is in flight.
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last     = (r_idx == LAST_IDX);
    assign w_bit_base = {r_idx, 2'b00};

    // Single-digit decimal add on the digit currently selected by r_idx.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_a_dig      = r_a[w_bit_base +: 4];
        w_b_dig      = r_b[w_bit_base +: 4];
        w_t          = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'b0000, r_carry};
        w_carry_next = (w_t > 5'd9);
        w_digit      = w_carry_next ? (w_t[3:0] + 4'd6) : w_t[3:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE/DONE accept a start, ADD runs for DIGITS cycles.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = w_accept ? S_ADD : S_IDLE;
            S_ADD:   w_state_next = w_last ? S_DONE : S_ADD;
            S_DONE:  w_state_next = w_accept ? S_ADD : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture on accept, then one sum digit per ADD cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_s     <= '0;
            r_idx   <= '0;
            r_carry <= cin;
            r_cout  <= 1'b0;
        end else if (r_state == S_ADD) begin
            r_s[w_bit_base +: 4] <= w_digit;
            r_carry              <= w_carry_next;
            if (w_last) begin
                r_idx  <= '0;
                r_cout <= w_carry_next;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic r_err;
    logic w_bad_digit;

    // True when any 4-bit digit of v is outside 0..9.
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    assign w_bad_digit = has_bad_digit(a) | has_bad_digit(b);

    // Sticky operand-validity flag, refreshed only when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_bad_digit;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign s    = r_s;
    assign cout = r_cout;
    assign busy = (r_state == S_ADD);
    assign done = (r_state == S_DONE);

endmodule
